// File: rtl/unified_mem.sv
// Unified instruction/data memory: clears itself after reset, then serves one word request at a time with a fixed-latency ready_o pulse.
// Optional misalignment detection is enabled with `define UNIFIED_MEM_ALIGN_CHECK_EN.
module unified_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        enable_wmem_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic [31:0] read_data_o32,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept;
  logic            req_mis;
  logic [AW-1:0]   req_idx;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic            unused_addr;

  assign req_idx     = addr_i32[AW+1:2];
  assign unused_addr = ^{addr_i32[31:AW+2], addr_i32[1:0]};
  assign accept      = (state_q == IDLE || state_q == RESP) && req_i;

`ifdef UNIFIED_MEM_ALIGN_CHECK_EN
  assign req_mis = (addr_i32[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
      rdata_q   <= rdata_d;
    end
  end

  // Array has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = req_idx;
    mem_wdata = write_data_i32;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) state_d = IDLE;
      end
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          idx_d  = req_idx;
          mis_d  = req_mis;
          mem_we = enable_wmem_i && !req_mis;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No WAIT cycle: the response word is resolved on the accepting edge.
            state_d = RESP;
            if (req_mis)            rdata_d = '0;
            else if (enable_wmem_i) rdata_d = write_data_i32;
            else                    rdata_d = mem_q[req_idx];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          rdata_d = mis_q ? '0 : mem_q[idx_q];
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ready_o = (state_q == RESP);
    busy_o  = (state_q != IDLE) && !(state_q == RESP && !req_i);
`ifdef UNIFIED_MEM_ALIGN_CHECK_EN
    err_o   = (state_q == RESP) && mis_q;
`else
    err_o   = 1'b0;
`endif
  end

  assign read_data_o32 = rdata_q;

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: a LATENCY=2 instance for most scenarios and a LATENCY=1 instance for streaming.
module tb_unified_mem;
  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy, err;
  logic        rst1_n, req1, we1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, busy1, err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unified_mem #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk_i(clk), .reset_i(rst_n), .req_i(req), .enable_wmem_i(we),
    .addr_i32(addr), .write_data_i32(wdata), .read_data_o32(rdata),
    .ready_o(ready), .busy_o(busy), .err_o(err)
  );

  unified_mem #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst1_n), .req_i(req1), .enable_wmem_i(we1),
    .addr_i32(addr1), .write_data_i32(wdata1), .read_data_o32(rdata1),
    .ready_o(ready1), .busy_o(busy1), .err_o(err1)
  );

  // One request on u_dut; inputs are scrambled right after acceptance.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat, output bit pulse_ok);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
    pulse_ok = !ready;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 400);
  endtask

  task automatic test_reset;
    int n;
    logic [31:0] rd; logic e; int lat; bit p;
    logic [31:0] addrs [3] = '{32'h000, 32'h200, 32'h3FC};
    rst_n = 1'b0; rst1_n = 1'b0;
    req = 0; we = 0; addr = 0; wdata = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL rst_busy got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b0)    begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0)   begin n_bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
    @(negedge clk);
    rst_n = 1'b1; rst1_n = 1'b1;
    wait_clear(n);
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL clear_cycles got %0d want 256", n); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL clear_busy_l1 got %b want 0", busy1); end
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, addrs[i], 32'h0, rd, e, lat, p);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clear_read[%h] got %h want 0", addrs[i], rd); end
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic e; int lat; bit p;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat, p);
    n_cmp++; if (lat != 1)            begin n_bad++; $display("FAIL wr_latency got %0d edges want 1", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_resp_data got %h want deadbeef", rd); end
    n_cmp++; if (!p)                  begin n_bad++; $display("FAIL wr_pulse got 2+ cycles want 1"); end
    xact(1'b0, 32'h10, 32'h0, rd, e, lat, p);
    n_cmp++; if (lat != 1)            begin n_bad++; $display("FAIL rd_latency got %0d edges want 1", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", rd); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_hold got %h want deadbeef", rdata); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic e; int lat; bit p;
    xact(1'b1, 32'h400, 32'h1234_5678, rd, e, lat, p);
    xact(1'b0, 32'h000, 32'h0, rd, e, lat, p);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL wrap_read got %h want 12345678", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE_0000 + 32'(i / 2) * 32'h111;
      @(negedge clk);
      req1 = 1'b1; we1 = (i % 2 == 0); addr1 = 32'h40 + 32'(i / 2) * 4; wdata1 = (i % 2 == 0) ? d : 32'h0BAD_0BAD;
      @(posedge clk); #1;
      n_cmp++; if (ready1 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, ready1); end
      n_cmp++; if (rdata1 !== d)    begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, rdata1, d); end
    end
    @(negedge clk);
    req1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ready1 !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got %b want 0", ready1); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat; bit p; int n; bit seen;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_ready got pulse want none"); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(n);
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL mid_clear_cycles got %0d want 256", n); end
    xact(1'b0, 32'h20, 32'h0, rd, e, lat, p);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_read got %h want 0", rd); end
  endtask

  task automatic test_align;
    logic [31:0] rd; logic e; int lat; bit p;
    xact(1'b1, 32'h20, 32'h1111_1111, rd, e, lat, p);
    xact(1'b1, 32'h21, 32'hAAAA_5555, rd, e, lat, p);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL mis_latency got %0d want 1", lat); end
`ifdef UNIFIED_MEM_ALIGN_CHECK_EN
    n_cmp++; if (e !== 1'b1)   begin n_bad++; $display("FAIL mis_err got %b want 1", e); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_data got %h want 0", rd); end
    xact(1'b0, 32'h20, 32'h0, rd, e, lat, p);
    n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL mis_prior got %h want 11111111", rd); end
    n_cmp++; if (e !== 1'b0)   begin n_bad++; $display("FAIL mis_err_clean got %b want 0", e); end
`else
    n_cmp++; if (e !== 1'b0)           begin n_bad++; $display("FAIL mis_err got %b want 0", e); end
    n_cmp++; if (rd !== 32'hAAAA_5555) begin n_bad++; $display("FAIL mis_data got %h want aaaa5555", rd); end
    xact(1'b0, 32'h23, 32'h0, rd, e, lat, p);
    n_cmp++; if (rd !== 32'hAAAA_5555) begin n_bad++; $display("FAIL mis_enclosing got %h want aaaa5555", rd); end
`endif
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    test_align;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
